// File: rtl/aes_pkg.sv
// Shared definitions for the AES key-schedule engine.
//   - legal (Nk, Nr) pairings and the schedule length helper (NW = 4*(Nr+1))
//   - xtime over GF(2^8) with reduction polynomial 0x11B
//   - forward AES S-box table (256 x 8)
//   - RotWord helper
//   - state type for the sequencer FSM
package aes_pkg;

    localparam int unsigned BLOCK_W = 128;

    localparam int unsigned NK_128 = 4;
    localparam int unsigned NR_128 = 10;
    localparam int unsigned NK_192 = 6;
    localparam int unsigned NR_192 = 12;
    localparam int unsigned NK_256 = 8;
    localparam int unsigned NR_256 = 14;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } ks_state_e;

    function automatic bit pair_legal(input int unsigned nk, input int unsigned nr);
        return ((nk == NK_128) && (nr == NR_128)) ||
               ((nk == NK_192) && (nr == NR_192)) ||
               ((nk == NK_256) && (nr == NR_256));
    endfunction

    // Number of 32-bit schedule words for a given round count.
    function automatic int unsigned num_words(input int unsigned nr);
        return 4 * (nr + 1);
    endfunction

    // Multiply by x in GF(2^8); 0x1B is the low byte of 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // (a0,a1,a2,a3) -> (a1,a2,a3,a0), a0 being the most significant byte.
    function automatic logic [31:0] rotword(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel forward S-box lookups (SubWord).
// Ports:
//   i_word  32-bit input word
//   o_word  32-bit output, each byte replaced by its S-box image
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    always_comb begin
        o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                  SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES key-schedule engine: one 32-bit schedule word per clock.
// Parameters:
//   N          block width, must be 128
//   Nk, Nr     key words / rounds: (4,10), (6,12) or (8,14)
//   DEC_ORDER  1: slot s holds round key Nr-s; 0: slot s holds round key s
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_start      begin an expansion (ignored while busy)
//   i_key        cipher key, w[0] in the top 32 bits
//   o_word       flat round-key bus, slot s at [128*s +: 128]
//   o_busy       expansion in progress
//   o_key_valid  bus complete and stable until the next accepted start or reset
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int unsigned N         = 128,
    parameter int unsigned Nk        = 4,
    parameter int unsigned Nr        = 10,
    parameter int unsigned DEC_ORDER = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [32*Nk-1:0]       i_key,
    output logic [128*(Nr+1)-1:0]  o_word,
    output logic                   o_busy,
    output logic                   o_key_valid
);

    localparam int unsigned NW = num_words(Nr);
    localparam int unsigned IW = $clog2(NW);
    localparam int unsigned KW = $clog2(Nk);

    localparam logic [IW-1:0] IDX_LAST  = IW'(NW - 1);
    localparam logic [IW-1:0] IDX_FIRST = IW'(Nk);
    localparam logic [KW-1:0] WRAP_LAST = KW'(Nk - 1);
    localparam logic [KW-1:0] WRAP_HALF = KW'(Nk / 2);

    if ((N != BLOCK_W) || !pair_legal(Nk, Nr)) begin : g_bad_params
        $error("aes_key_expand_seq: illegal N/Nk/Nr combination");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ks_state_e     r_state;
    ks_state_e     w_state_d;
    logic [31:0]   r_w [NW];
    logic [IW-1:0] r_i;
    logic [KW-1:0] r_wrap;     // i mod Nk, kept incrementally
    logic [7:0]    r_rcon;
    logic          r_valid;

    logic          w_load;
    logic          w_step;
    logic          w_last;
    logic          w_valid_d;

    logic [IW-1:0] w_idx_prev;
    logic [IW-1:0] w_idx_back;
    logic [31:0]   w_prev;
    logic [31:0]   w_back;
    logic [31:0]   w_sub_in;
    logic [31:0]   w_sub_out;
    logic [31:0]   w_temp;
    logic [31:0]   w_new;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_last    = (r_i == IDX_LAST);
        w_valid_d = r_valid;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_load    = 1'b1;
                    w_valid_d = 1'b0;
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_valid_d = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Schedule word computation
    // ------------------------------------------------------------------
    always_comb begin
        w_idx_prev = r_i - IW'(1);
        w_idx_back = r_i - IW'(Nk);
        w_prev     = r_w[w_idx_prev];
        w_back     = r_w[w_idx_back];
        // One S-box instance: the rotate path and the Nk=8 mid-key path never coincide.
        w_sub_in   = (r_wrap == '0) ? rotword(w_prev) : w_prev;
        w_temp     = w_prev;
        if (r_wrap == '0) begin
            w_temp = w_sub_out ^ {r_rcon, 24'h000000};
        end else if ((Nk == 8) && (r_wrap == WRAP_HALF)) begin
            w_temp = w_sub_out;
        end
        w_new = w_back ^ w_temp;
    end

    aes_sbox_word u_sbox (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_i     <= '0;
            r_wrap  <= '0;
            r_rcon  <= '0;
            r_valid <= 1'b0;
            for (int k = 0; k < NW; k++) begin
                r_w[k] <= '0;
            end
        end else begin
            r_valid <= w_valid_d;
            if (w_load) begin
                for (int k = 0; k < Nk; k++) begin
                    r_w[k] <= i_key[32*(Nk-k)-1 -: 32];
                end
                r_i    <= IDX_FIRST;
                r_wrap <= '0;
                r_rcon <= 8'h01;
            end else if (w_step) begin
                r_w[r_i] <= w_new;
                if (!w_last) begin
                    r_i <= r_i + IW'(1);
                end
                r_wrap <= (r_wrap == WRAP_LAST) ? '0 : r_wrap + KW'(1);
                if (r_wrap == '0) begin
                    r_rcon <= xtime(r_rcon);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: static remap of the word store
    // ------------------------------------------------------------------
    for (genvar s = 0; s < int'(Nr) + 1; s++) begin : g_slot
        localparam int unsigned R = (DEC_ORDER != 0) ? (Nr - s) : s;
        assign o_word[128*s +: 128] = {r_w[4*R], r_w[4*R+1], r_w[4*R+2], r_w[4*R+3]};
    end

    assign o_busy      = (r_state == StRun);
    assign o_key_valid = r_valid;

endmodule
